// File: rtl/inst_encoder_pkg.sv
// Shared codes for the instruction encoder: INST_* record codes,
// MIPS opcode/funct fields, run-control states and the record bundle.
package inst_encoder_pkg;

   localparam logic [5:0] INST_NOP   = 6'd0;
   localparam logic [5:0] INST_ADDU  = 6'd1;
   localparam logic [5:0] INST_SUBU  = 6'd2;
   localparam logic [5:0] INST_SLT   = 6'd3;
   localparam logic [5:0] INST_SRAV  = 6'd4;
   localparam logic [5:0] INST_JR    = 6'd5;
   localparam logic [5:0] INST_ORI   = 6'd6;
   localparam logic [5:0] INST_LW    = 6'd7;
   localparam logic [5:0] INST_SW    = 6'd8;
   localparam logic [5:0] INST_BEQ   = 6'd9;
   localparam logic [5:0] INST_ADDI  = 6'd10;
   localparam logic [5:0] INST_ADDIU = 6'd11;
   localparam logic [5:0] INST_LB    = 6'd12;
   localparam logic [5:0] INST_SB    = 6'd13;
   localparam logic [5:0] INST_LUI   = 6'd14;
   localparam logic [5:0] INST_J     = 6'd15;
   localparam logic [5:0] INST_JAL   = 6'd16;
   localparam logic [5:0] INST_HLT   = 6'd17;

   localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
   localparam logic [5:0] OPCODE_J       = 6'h02;
   localparam logic [5:0] OPCODE_JAL     = 6'h03;
   localparam logic [5:0] OPCODE_BEQ     = 6'h04;
   localparam logic [5:0] OPCODE_ADDI    = 6'h08;
   localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
   localparam logic [5:0] OPCODE_ORI     = 6'h0D;
   localparam logic [5:0] OPCODE_LUI     = 6'h0F;
   localparam logic [5:0] OPCODE_LB      = 6'h20;
   localparam logic [5:0] OPCODE_LW      = 6'h23;
   localparam logic [5:0] OPCODE_SB      = 6'h28;
   localparam logic [5:0] OPCODE_SW      = 6'h2B;
   localparam logic [5:0] OPCODE_HLT     = 6'h3F;

   localparam logic [5:0] FUNCT_SRAV = 6'h07;
   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   typedef enum logic [1:0] {
      ENC_IDLE,
      ENC_RUN,
      ENC_DRAIN,
      ENC_DONE
   } enc_state_e;

   typedef struct packed {
      logic [5:0]  inst;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic [25:0] target;
   } rec_t;

   function automatic logic [31:0] r_word(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [5:0] fn
   );
      return {OPCODE_SPECIAL, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_word(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [15:0] imm
   );
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational record-to-word packer; flags records whose forced-zero
// fields are nonzero or whose code is unknown.
import inst_encoder_pkg::*;

module inst_pack (
   input  rec_t        rec,
   output logic [31:0] word,
   output logic        illegal
);

   logic any_field;

   assign any_field = |{rec.rs, rec.rt, rec.rd, rec.shamt,
                        rec.imm, rec.target};

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (rec.inst)
         INST_ADDU: begin
            word    = r_word(rec.rs, rec.rt, rec.rd, FUNCT_ADDU);
            illegal = |rec.shamt;
         end
         INST_SUBU: begin
            word    = r_word(rec.rs, rec.rt, rec.rd, FUNCT_SUBU);
            illegal = |rec.shamt;
         end
         INST_SLT: begin
            word    = r_word(rec.rs, rec.rt, rec.rd, FUNCT_SLT);
            illegal = |rec.shamt;
         end
         INST_SRAV: begin
            word    = r_word(rec.rs, rec.rt, rec.rd, FUNCT_SRAV);
            illegal = |rec.shamt;
         end
         INST_JR: begin
            word    = r_word(rec.rs, 5'd0, 5'd0, FUNCT_JR);
            illegal = |{rec.rt, rec.rd, rec.shamt};
         end
         INST_ORI:   word = i_word(OPCODE_ORI, rec.rs, rec.rt, rec.imm);
         INST_LW:    word = i_word(OPCODE_LW, rec.rs, rec.rt, rec.imm);
         INST_SW:    word = i_word(OPCODE_SW, rec.rs, rec.rt, rec.imm);
         INST_BEQ:   word = i_word(OPCODE_BEQ, rec.rs, rec.rt, rec.imm);
         INST_ADDI:  word = i_word(OPCODE_ADDI, rec.rs, rec.rt, rec.imm);
         INST_ADDIU: word = i_word(OPCODE_ADDIU, rec.rs, rec.rt, rec.imm);
         INST_LB:    word = i_word(OPCODE_LB, rec.rs, rec.rt, rec.imm);
         INST_SB:    word = i_word(OPCODE_SB, rec.rs, rec.rt, rec.imm);
         INST_LUI: begin
            word    = i_word(OPCODE_LUI, 5'd0, rec.rt, rec.imm);
            illegal = |rec.rs;
         end
         INST_J:   word = {OPCODE_J, rec.target};
         INST_JAL: word = {OPCODE_JAL, rec.target};
         // HLT and NOP are fixed words, so every field must be zero
         INST_HLT: begin
            word    = {OPCODE_HLT, 26'd0};
            illegal = any_field;
         end
         INST_NOP: illegal = any_field;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: run-control FSM, address counter, one registered
// output stage with valid/ready handshakes and a saturating error count.
import inst_encoder_pkg::*;

module inst_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_inst,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic              done
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   enc_state_e        state;
   logic [ADDR_W-1:0] cnt;
   rec_t              rec;
   logic [31:0]       word;
   logic              illegal;
   logic              accept;
   logic              drained;

   assign rec = {in_inst, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target};
   assign in_ready = (state == ENC_RUN) && (!out_valid || out_ready);
   assign accept = in_valid && in_ready;
   assign drained = out_valid && out_ready;

   inst_pack u_pack (
      .rec     (rec),
      .word    (word),
      .illegal (illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ENC_IDLE;
         cnt       <= BASE;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_addr  <= BASE;
         err       <= 1'b0;
         err_cnt   <= '0;
         done      <= 1'b0;
      end else begin
         if (drained)
            out_valid <= 1'b0;
         // an accept in the same cycle as a drain refills with no bubble
         if (accept) begin
            out_valid <= 1'b1;
            out_word  <= word;
            out_addr  <= cnt;
            cnt       <= cnt + 1'b1;
            if (illegal) begin
               err <= 1'b1;
               if (err_cnt != 8'hFF)
                  err_cnt <= err_cnt + 8'd1;
            end
         end
         case (state)
            ENC_IDLE: begin
               if (start) begin
                  state <= ENC_RUN;
                  cnt   <= BASE;
               end
            end
            ENC_RUN: begin
               if (accept && rec.inst == INST_HLT)
                  state <= ENC_DRAIN;
            end
            ENC_DRAIN: begin
               if (drained) begin
                  state <= ENC_DONE;
                  done  <= 1'b1;
               end
            end
            ENC_DONE: begin
               if (start) begin
                  state   <= ENC_RUN;
                  cnt     <= BASE;
                  err     <= 1'b0;
                  err_cnt <= '0;
                  done    <= 1'b0;
               end
            end
            default: state <= ENC_IDLE;
         endcase
      end
   end

endmodule
